// File: rtl/zigzag_input_pkg.sv
// Shared constants and types for the zigzag player-input front end:
// PS/2 scancodes, joystick/direction bit positions and the auto-coin state enum.
package zigzag_input_pkg;

  typedef enum logic [2:0] {StIdle, StCoin, StGap, StStart, StHold} seq_state_e;

  // Arrow keys are matched on the low byte only, so both plain and extended codes hit.
  localparam logic [7:0] ScArrowUp    = 8'h75;
  localparam logic [7:0] ScArrowDown  = 8'h72;
  localparam logic [7:0] ScArrowLeft  = 8'h6B;
  localparam logic [7:0] ScArrowRight = 8'h74;

  localparam logic [8:0] ScSpace   = 9'h029;
  localparam logic [8:0] ScCtrl    = 9'h014;
  localparam logic [8:0] ScF1      = 9'h005;
  localparam logic [8:0] ScF2      = 9'h006;
  localparam logic [8:0] ScKey1    = 9'h016;
  localparam logic [8:0] ScKey2    = 9'h01E;
  localparam logic [8:0] ScKey5    = 9'h02E;
  localparam logic [8:0] ScKey6    = 9'h036;
  localparam logic [8:0] ScP2Up    = 9'h02D;
  localparam logic [8:0] ScP2Down  = 9'h02B;
  localparam logic [8:0] ScP2Left  = 9'h023;
  localparam logic [8:0] ScP2Right = 9'h034;
  localparam logic [8:0] ScP2Fire  = 9'h01C;
  localparam logic [8:0] ScTest    = 9'h02C;

  // Bit positions inside the {up,down,left,right} direction nibble.
  localparam int unsigned DirUp    = 3;
  localparam int unsigned DirDown  = 2;
  localparam int unsigned DirLeft  = 1;
  localparam int unsigned DirRight = 0;

  localparam int unsigned JoyR      = 0;
  localparam int unsigned JoyL      = 1;
  localparam int unsigned JoyD      = 2;
  localparam int unsigned JoyU      = 3;
  localparam int unsigned JoyFire   = 4;
  localparam int unsigned JoyStart1 = 5;
  localparam int unsigned JoyStart2 = 6;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire;
    logic f1;
    logic f2;
    logic k1;
    logic k2;
    logic k5;
    logic k6;
    logic p2_up;
    logic p2_down;
    logic p2_left;
    logic p2_right;
    logic p2_fire;
    logic test;
  } keys_t;

  // Horizontal cabinet remap: up<-left, down<-right, left<-down, right<-up.
  function automatic logic [3:0] rotate_dir(logic [3:0] d, logic rot);
    return rot ? {d[DirLeft], d[DirRight], d[DirDown], d[DirUp]} : d;
  endfunction

endpackage

// File: rtl/zigzag_autocoin_seq.sv
// Auto-coin sequencer: a start press becomes coin pulse, idle gap, then start pulse.
// Coin keys run only the coin phase. Outputs reflect the next state for the top to register.
module zigzag_autocoin_seq
  import zigzag_input_pkg::*;
#(
  parameter int unsigned COIN_CYCLES  = 1200000,
  parameter int unsigned GAP_CYCLES   = 120000,
  parameter int unsigned START_CYCLES = 1200000,
  parameter int unsigned CNT_W        = 21
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start1_req_i,
  input  logic start2_req_i,
  input  logic coin_req_i,
  output logic coin_o,
  output logic start1_o,
  output logic start2_o
);

  localparam logic [CNT_W-1:0] CoinLoad  = CNT_W'(COIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] StartLoad = CNT_W'(START_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             sel2_q, sel2_d;
  logic             coin_only_q, coin_only_d;
  logic             start_prev_q, coin_prev_q;
  logic             start_any, start_rise, coin_rise;

  assign start_any  = start1_req_i | start2_req_i;
  assign start_rise = start_any & ~start_prev_q;
  assign coin_rise  = coin_req_i & ~coin_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      sel2_q       <= 1'b0;
      coin_only_q  <= 1'b0;
      start_prev_q <= 1'b0;
      coin_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sel2_q       <= sel2_d;
      coin_only_q  <= coin_only_d;
      start_prev_q <= start_any;
      coin_prev_q  <= coin_req_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q != '0) ? timer_q - 1'b1 : '0;
    sel2_d      = sel2_q;
    coin_only_d = coin_only_q;
    case (state_q)
      StIdle: begin
        // A joystick start outranks a coin key arriving in the same cycle.
        if (start_rise) begin
          state_d     = StCoin;
          timer_d     = CoinLoad;
          sel2_d      = ~start1_req_i;
          coin_only_d = 1'b0;
        end else if (coin_rise) begin
          state_d     = StCoin;
          timer_d     = CoinLoad;
          coin_only_d = 1'b1;
        end
      end
      StCoin: begin
        if (timer_q == '0) begin
          if (coin_only_q) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            timer_d = GapLoad;
          end
        end
      end
      StGap: begin
        if (timer_q == '0) begin
          state_d = StStart;
          timer_d = StartLoad;
        end
      end
      StStart: begin
        if (timer_q == '0) state_d = StHold;
      end
      StHold: begin
        if (!start_any) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    coin_o   = (state_d == StCoin);
    start1_o = (state_d == StStart) & ~sel2_d;
    start2_o = (state_d == StStart) & sel2_d;
  end

endmodule

// File: rtl/zigzag_input_ctrl.sv
// Player-input front end for the galaxian core: PS/2 key latches, joystick merge,
// orientation remap and auto-coin pulses, all presented on registered outputs.
module zigzag_input_ctrl
  import zigzag_input_pkg::*;
#(
  parameter int unsigned COIN_CYCLES  = 1200000,
  parameter int unsigned GAP_CYCLES   = 120000,
  parameter int unsigned START_CYCLES = 1200000,
  parameter int unsigned CNT_W        = 21
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [3:0]  p1_dir,
  output logic        p1_fire,
  output logic [3:0]  p2_dir,
  output logic        p2_fire,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic        test
);

  logic        tog_q;
  keys_t       keys_q, keys_d;
  logic [15:0] joy;
  logic [3:0]  p1_raw, p2_raw;
  logic [3:0]  p1_dir_q, p2_dir_q;
  logic        p1_fire_q, p2_fire_q, start1_q, start2_q, coin1_q, test_q;
  logic        seq_coin, seq_start1, seq_start2;
  logic        unused_joy;

  assign joy        = joystick_0 | joystick_1;
  assign unused_joy = ^joy[15:7];

  // Key latches; outputs are built from keys_d so a key event shows up one cycle later.
  always_comb begin
    keys_d = keys_q;
    if (ps2_key[10] != tog_q) begin
      case (ps2_key[7:0])
        ScArrowUp:    keys_d.up    = ps2_key[9];
        ScArrowDown:  keys_d.down  = ps2_key[9];
        ScArrowLeft:  keys_d.left  = ps2_key[9];
        ScArrowRight: keys_d.right = ps2_key[9];
        default: begin
          case (ps2_key[8:0])
            ScSpace, ScCtrl: keys_d.fire     = ps2_key[9];
            ScF1:            keys_d.f1       = ps2_key[9];
            ScF2:            keys_d.f2       = ps2_key[9];
            ScKey1:          keys_d.k1       = ps2_key[9];
            ScKey2:          keys_d.k2       = ps2_key[9];
            ScKey5:          keys_d.k5       = ps2_key[9];
            ScKey6:          keys_d.k6       = ps2_key[9];
            ScP2Up:          keys_d.p2_up    = ps2_key[9];
            ScP2Down:        keys_d.p2_down  = ps2_key[9];
            ScP2Left:        keys_d.p2_left  = ps2_key[9];
            ScP2Right:       keys_d.p2_right = ps2_key[9];
            ScP2Fire:        keys_d.p2_fire  = ps2_key[9];
            ScTest:          keys_d.test     = ps2_key[9];
            default: ;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    p1_raw = {keys_d.up | joy[JoyU], keys_d.down | joy[JoyD],
              keys_d.left | joy[JoyL], keys_d.right | joy[JoyR]};
    p2_raw = {keys_d.p2_up | joy[JoyU], keys_d.p2_down | joy[JoyD],
              keys_d.p2_left | joy[JoyL], keys_d.p2_right | joy[JoyR]};
  end

  zigzag_autocoin_seq #(
    .COIN_CYCLES  (COIN_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES),
    .START_CYCLES (START_CYCLES),
    .CNT_W        (CNT_W)
  ) u_seq (
    .clk_i        (clk_sys),
    .rst_i        (reset),
    .start1_req_i (joy[JoyStart1] | keys_d.f1),
    .start2_req_i (joy[JoyStart2] | keys_d.f2),
    .coin_req_i   (keys_d.k5 | keys_d.k6),
    .coin_o       (seq_coin),
    .start1_o     (seq_start1),
    .start2_o     (seq_start2)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q     <= ps2_key[10];
      keys_q    <= '0;
      p1_dir_q  <= '0;
      p2_dir_q  <= '0;
      p1_fire_q <= 1'b0;
      p2_fire_q <= 1'b0;
      start1_q  <= 1'b0;
      start2_q  <= 1'b0;
      coin1_q   <= 1'b0;
      test_q    <= 1'b0;
    end else begin
      tog_q     <= ps2_key[10];
      keys_q    <= keys_d;
      p1_dir_q  <= rotate_dir(p1_raw, rotate);
      p2_dir_q  <= rotate_dir(p2_raw, rotate);
      p1_fire_q <= keys_d.fire | joy[JoyFire];
      p2_fire_q <= keys_d.p2_fire | joy[JoyFire];
      start1_q  <= seq_start1 | keys_d.k1;
      start2_q  <= seq_start2 | keys_d.k2;
      coin1_q   <= seq_coin;
      test_q    <= keys_d.test;
    end
  end

  assign p1_dir  = p1_dir_q;
  assign p2_dir  = p2_dir_q;
  assign p1_fire = p1_fire_q;
  assign p2_fire = p2_fire_q;
  assign start1  = start1_q;
  assign start2  = start2_q;
  assign coin1   = coin1_q;
  assign test    = test_q;

endmodule

// File: tb/tb_zigzag_input_ctrl.sv
// Scoreboard bench for zigzag_input_ctrl: each driven cycle queues the expected output word,
// and a monitor pops and compares it just after the following rising edge.
module tb_zigzag_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        rotate;
  logic [3:0]  p1_dir, p2_dir;
  logic        p1_fire, p2_fire, start1, start2, coin1, test;
  logic [13:0] out_w;

  // Output word: {p1_dir, p1_fire, p2_dir, p2_fire, start1, start2, coin1, test}
  localparam logic [13:0] P1Up   = 14'h2000;
  localparam logic [13:0] P1Left = 14'h0800;
  localparam logic [13:0] P1Fire = 14'h0200;
  localparam logic [13:0] P2Up   = 14'h0100;
  localparam logic [13:0] P2Left = 14'h0040;
  localparam logic [13:0] P2Fire = 14'h0010;
  localparam logic [13:0] S1     = 14'h0008;
  localparam logic [13:0] S2     = 14'h0004;
  localparam logic [13:0] Coin   = 14'h0002;
  localparam logic [13:0] Test   = 14'h0001;

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk_sys = ~clk_sys;

  zigzag_input_ctrl #(
    .COIN_CYCLES  (8),
    .GAP_CYCLES   (4),
    .START_CYCLES (8),
    .CNT_W        (4)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .rotate     (rotate),
    .p1_dir     (p1_dir),
    .p1_fire    (p1_fire),
    .p2_dir     (p2_dir),
    .p2_fire    (p2_fire),
    .start1     (start1),
    .start2     (start2),
    .coin1      (coin1),
    .test       (test)
  );

  assign out_w = {p1_dir, p1_fire, p2_dir, p2_fire, start1, start2, coin1, test};

  task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk_sys) begin
    #1;
    if (sb_q.size() != 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, out_w, e.exp);
    end
  end

  // Called at a falling edge with inputs already set: queue n expectations, one per cycle.
  task automatic expect_n(input string tag, input logic [13:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      sb_t s;
      s.tag = $sformatf("%s[%0d]", tag, i);
      s.exp = e;
      sb_q.push_back(s);
      @(negedge clk_sys);
    end
  endtask

  task automatic send_key(input logic [8:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic run_seq(input string tag, input logic [13:0] start_w);
    expect_n({tag, "_coin"}, Coin, 8);
    expect_n({tag, "_gap"}, 14'h0, 4);
    expect_n({tag, "_start"}, start_w, 8);
  endtask

  initial begin
    reset      = 1'b1;
    ps2_key    = '0;
    joystick_0 = '0;
    joystick_1 = '0;
    rotate     = 1'b0;
    @(negedge clk_sys);
    expect_n("reset", 14'h0, 2);
    reset = 1'b0;
    expect_n("idle", 14'h0, 2);

    // PS/2 key latches
    send_key(9'h075, 1'b1); expect_n("arrow_up", P1Up, 2);
    send_key(9'h075, 1'b0); expect_n("arrow_up_rel", 14'h0, 1);
    send_key(9'h175, 1'b1); expect_n("ext_up", P1Up, 1);
    send_key(9'h175, 1'b0); expect_n("ext_up_rel", 14'h0, 1);
    send_key(9'h114, 1'b1); expect_n("ext_ctrl_ignored", 14'h0, 1);
    send_key(9'h114, 1'b0); expect_n("ext_ctrl_rel", 14'h0, 1);
    send_key(9'h029, 1'b1); expect_n("p1_fire", P1Fire, 1);
    send_key(9'h029, 1'b0); expect_n("p1_fire_rel", 14'h0, 1);
    send_key(9'h01C, 1'b1); expect_n("p2_fire", P2Fire, 1);
    send_key(9'h01C, 1'b0); expect_n("p2_fire_rel", 14'h0, 1);
    send_key(9'h02D, 1'b1); expect_n("p2_up", P2Up, 1);
    send_key(9'h02D, 1'b0); expect_n("p2_up_rel", 14'h0, 1);
    send_key(9'h02C, 1'b1); expect_n("test_key", Test, 1);
    send_key(9'h02C, 1'b0); expect_n("test_rel", 14'h0, 1);
    send_key(9'h016, 1'b1); expect_n("key1_level", S1, 3);
    send_key(9'h016, 1'b0); expect_n("key1_rel", 14'h0, 1);
    send_key(9'h05A, 1'b1); expect_n("unlisted", 14'h0, 1);
    send_key(9'h05A, 1'b0); expect_n("unlisted_rel", 14'h0, 1);

    // Joystick merge and orientation remap
    joystick_0[1] = 1'b1; expect_n("joy_left", P1Left | P2Left, 1);
    rotate = 1'b1;        expect_n("rot_left_to_up", P1Up | P2Up, 1);
    joystick_0[1] = 1'b0;
    joystick_1[1] = 1'b1; expect_n("rot_joy1", P1Up | P2Up, 1);
    joystick_1[1] = 1'b0;
    rotate = 1'b0;        expect_n("joy_clear", 14'h0, 1);

    // Auto-coin from joystick start1, then an identical repeat
    joystick_0[5] = 1'b1; run_seq("auto1", S1);
    expect_n("auto1_hold", 14'h0, 3);
    joystick_0[5] = 1'b0; expect_n("auto1_rel", 14'h0, 2);
    joystick_0[5] = 1'b1; run_seq("auto1_again", S1);
    joystick_0[5] = 1'b0; expect_n("auto1_again_rel", 14'h0, 2);

    // Both starts together -> start1 wins; a fresh trigger during GAP is ignored
    joystick_0[6:5] = 2'b11; expect_n("both_coin", Coin, 8);
    joystick_0[6:5] = 2'b00; expect_n("both_gap0", 14'h0, 1);
    joystick_0[6]   = 1'b1;  expect_n("both_gap_retrig", 14'h0, 3);
    expect_n("both_start", S1, 8);
    expect_n("both_hold", 14'h0, 2);
    joystick_0[6] = 1'b0; expect_n("both_rel", 14'h0, 2);

    // Coin key: coin phase only, held level does not extend it
    send_key(9'h02E, 1'b1); expect_n("key5_coin", Coin, 8);
    expect_n("key5_after", 14'h0, 4);
    send_key(9'h02E, 1'b0); expect_n("key5_rel", 14'h0, 2);

    // F2 behaves as joystick start2
    send_key(9'h006, 1'b1); run_seq("f2", S2);
    send_key(9'h006, 1'b0); expect_n("f2_rel", 14'h0, 2);

    // Reset in the middle of START
    joystick_0[5] = 1'b1;
    expect_n("mid_coin", Coin, 8);
    expect_n("mid_gap", 14'h0, 4);
    expect_n("mid_start", S1, 3);
    reset = 1'b1; joystick_0[5] = 1'b0;
    expect_n("mid_reset", 14'h0, 2);
    reset = 1'b0;
    expect_n("post_reset", 14'h0, 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
